contador_universal: RTL

- Parametrised successor to the team's basic 4-bit up counter.
- Counts up or down to a configurable modulus.
- Supports synchronous clear, parallel load, count enable and three terminal behaviours: wrap, saturate, one-shot.
- Provides a combinational terminal-count output for cascading stages (e.g. BCD digit chains) and a registered wrap pulse.
- Used wherever datapaths and timers need a decade, modulo-N or one-shot counter.

---
 rtl/contador_universal_if.sv | 26 ++
 rtl/contador_universal.sv | 75 +++++++
 2 files changed

// File: rtl/contador_universal_if.sv
// Control and status bundle for contador_universal.
// The master drives controls and observes the count; the slave is the counter.
interface contador_universal_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cuenta;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, up, clr, load, load_val, mode,
    input  cuenta, tc, wrap, done
  );

  modport slave (
    input  en, up, clr, load, load_val, mode,
    output cuenta, tc, wrap, done
  );
endinterface

// File: rtl/contador_universal.sv
// Up/down modulo counter with wrap, saturate and one-shot terminal behaviours.
// State updates on the falling clock edge; tc is combinational for cascading.
module contador_universal #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input logic               clk,
  input logic               rst,
  contador_universal_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  typedef enum logic {RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] cuenta_q, cuenta_next;
  logic             wrap_q, wrap_next;
  logic             done_q;
  logic [WIDTH-1:0] terminal;
  logic             at_term;

  always_comb begin
    terminal    = bus.up ? MAX_V : '0;
    at_term     = (cuenta_q == terminal);
    state_next  = state;
    cuenta_next = cuenta_q;
    wrap_next   = 1'b0;
    if (bus.clr) begin
      cuenta_next = RST_V;
      state_next  = RUN;
    end else if (bus.load) begin
      cuenta_next = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      state_next  = RUN;
    end else if (state == DONE) begin
      // Leaving DONE via a mode change releases the hold but does not count that edge.
      if (bus.mode != 2'b10) state_next = RUN;
    end else if (bus.en) begin
      if (!at_term) begin
        cuenta_next = bus.up ? cuenta_q + WIDTH'(1) : cuenta_q - WIDTH'(1);
      end else begin
        case (bus.mode)
          2'b01:   ;
          2'b10:   state_next = DONE;
          default: begin
            cuenta_next = bus.up ? '0 : MAX_V;
            wrap_next   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cuenta_q <= RST_V;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cuenta_q <= cuenta_next;
      wrap_q   <= wrap_next;
      done_q   <= (state_next == DONE);
    end
  end

  assign bus.cuenta = cuenta_q;
  assign bus.wrap   = wrap_q;
  assign bus.done   = done_q;
  assign bus.tc     = bus.en & at_term & (state == RUN) & ~bus.clr & ~bus.load;

endmodule
